// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the divided-clock period meter and its sync/edge front end.
// Defaults, FSM state type and the nominal 10 kHz reference period.
package clk_period_meter_pkg;

   localparam int unsigned CNT_W_DEFAULT       = 32;
   localparam int unsigned TIMEOUT_DEFAULT     = 100000000;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   // 10 kHz divided clock seen from a 100 MHz system clock
   localparam int unsigned PERIOD_10K_AT_100M  = 10000;

   typedef enum logic [0:0] {
      WAIT_FIRST = 1'b0,
      MEASURE    = 1'b1
   } state_t;

endpackage

// File: rtl/clk_period_meter_sync.sv
// Multi-flop synchronizer for a slow asynchronous clock plus rise/fall pulse detection.
// Reusable by any block that consumes the team's divided clocks.
module sync_edge_detect
   import clk_period_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic lvl,
   output logic rise,
   output logic fall
);

   // fewer than two flops gives no metastability protection
   localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [NSYNC-1:0] sync_p0;
   logic             lvl_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         lvl_d   <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[NSYNC-2:0], async_in};
         lvl_d   <= lvl;
      end
   end

   assign lvl  = sync_p0[NSYNC-1];
   assign rise = lvl & ~lvl_d;
   assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock cycles,
// delivering each result over valid/ready with overrun and stuck-input flags.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_clk,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   input  logic             ready,
   output logic             overrun,
   output logic             stuck,
   input  logic             clr_err
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic             lvl;
   logic             rise;
   logic             fall_unused;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] lvl_ext;

   logic             cand;
   logic             accept;
   logic             load;
   logic             drop;
   logic             timeout;

   // fall is part of the shared front end; this block only times rising edges
   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (in_clk),
      .lvl      (lvl),
      .rise     (rise),
      .fall     (fall_unused)
   );

   assign lvl_ext = {{(CNT_W-1){1'b0}}, lvl};

   // A rise in MEASURE closes a full period; a rise always beats a timeout in the same cycle.
   always_comb begin
      cand    = (state == MEASURE) && rise;
      accept  = valid && ready;
      load    = cand && (!valid || ready);
      drop    = cand && valid && !ready;
      timeout = 1'b0;
      if (!rise) begin
         if (state == MEASURE) timeout = (cnt == TIMEOUT_C);
         else                  timeout = (wcnt == TIMEOUT_C);
      end
   end

   // Measurement FSM: cnt/hcnt count the current period, wcnt times out the wait for a first edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_FIRST;
         cnt   <= '0;
         hcnt  <= '0;
         wcnt  <= '0;
         stuck <= 1'b0;
      end else if (rise) begin
         state <= MEASURE;
         cnt   <= ONE;
         hcnt  <= ONE;
         wcnt  <= '0;
         stuck <= 1'b0;
      end else if (timeout) begin
         state <= WAIT_FIRST;
         cnt   <= '0;
         hcnt  <= '0;
         wcnt  <= '0;
         stuck <= 1'b1;
      end else if (state == MEASURE) begin
         cnt   <= cnt + ONE;
         hcnt  <= hcnt + lvl_ext;
      end else begin
         wcnt  <= wcnt + ONE;
      end
   end

   // Single-entry output slot: a new result may replace one that is being accepted this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            period    <= cnt;
            high_time <= hcnt;
            valid     <= 1'b1;
         end else if (accept) begin
            valid     <= 1'b0;
         end
         if (drop)         overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: in_clk built from high/low segments, results checked
// against a segment-level model of completed periods.
module tb_clk_period_meter;
   import clk_period_meter_pkg::*;

   localparam int CNT_W = 32;
   localparam int TO    = 12000;

   logic             clk;
   logic             rst_n;
   logic             in_clk;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             ready;
   logic             overrun;
   logic             stuck;
   logic             clr_err;

   typedef struct {
      int p;
      int h;
   } res_t;

   res_t exp_q[$];
   res_t r;
   int   checks = 0;
   int   errors = 0;
   int   n_acc  = 0;

   // model: a full period is every pair of rises not separated by more than TO cycles
   bit   armed   = 1'b0;
   bit   prev_in = 1'b0;
   int   acc_p   = 0;
   int   acc_h   = 0;

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TO),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_clk    (in_clk),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .ready     (ready),
      .overrun   (overrun),
      .stuck     (stuck),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_seg(input bit v, input int n);
      if (v && !prev_in) begin
         if (armed && acc_p <= TO) exp_q.push_back('{p: acc_p, h: acc_h});
         armed = 1'b1;
         acc_p = 0;
         acc_h = 0;
      end
      acc_p += n;
      if (v) acc_h += n;
      prev_in = v;
   endtask

   task automatic seg(input bit v, input int n);
      model_seg(v, n);
      in_clk = v;
      tick(n);
   endtask

   task automatic model_reset();
      armed   = 1'b0;
      prev_in = 1'b0;
      acc_p   = 0;
      acc_h   = 0;
      exp_q.delete();
   endtask

   // every accepted result must be the oldest outstanding model period
   always @(negedge clk) begin
      if (rst_n && valid === 1'b1 && ready === 1'b1) begin
         n_acc++;
         check("pending_result", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("period", period, r.p);
            check("high_time", high_time, r.h);
         end
      end
   end

   initial begin
      int h;
      int l;
      int k;
      int base;

      rst_n   = 1'b0;
      in_clk  = 1'b0;
      ready   = 1'b1;
      clr_err = 1'b0;
      tick(3);
      check("reset_period", period, 0);
      check("reset_high_time", high_time, 0);
      check("reset_valid", valid, 0);
      check("reset_overrun", overrun, 0);
      check("reset_stuck", stuck, 0);
      rst_n = 1'b1;
      tick(2);

      // 10 kHz divided clock
      for (int i = 0; i < 3; i++) begin
         seg(1'b1, PERIOD_10K_AT_100M / 2);
         seg(1'b0, PERIOD_10K_AT_100M / 2);
      end
      seg(1'b1, 5);
      seg(1'b0, 20);
      check("div10k_queue_empty", exp_q.size(), 0);
      check("div10k_period", period, 10000);
      check("div10k_high", high_time, 5000);
      check("div10k_overrun", overrun, 0);
      check("div10k_stuck", stuck, 0);

      // 30% duty, period 1000
      for (int i = 0; i < 4; i++) begin
         seg(1'b1, 300);
         seg(1'b0, 700);
      end
      seg(1'b1, 300);
      seg(1'b0, 50);
      check("duty30_queue_empty", exp_q.size(), 0);
      check("duty30_period", period, 1000);
      check("duty30_high", high_time, 300);

      // random high/low lengths
      for (int i = 0; i < 25; i++) begin
         h = $urandom_range(1, 30);
         l = $urandom_range(1, 30);
         seg(1'b1, h);
         seg(1'b0, l);
      end
      seg(1'b1, 5);
      seg(1'b0, 10);
      check("random_queue_empty", exp_q.size(), 0);

      // fastest input: toggling every clk
      for (int i = 0; i < 20; i++) begin
         seg(1'b1, 1);
         seg(1'b0, 1);
      end
      seg(1'b1, 1);
      seg(1'b0, 10);
      check("min_queue_empty", exp_q.size(), 0);
      check("min_period", period, 2);
      check("min_high", high_time, 1);
      check("min_overrun", overrun, 0);

      // backpressure: first result held, later ones dropped
      seg(1'b1, 10);
      seg(1'b0, 10);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seg(1'b1, 10);
         seg(1'b0, 10);
      end
      check("bp_valid_held", valid, 1);
      check("bp_period_held", period, 20);
      check("bp_high_held", high_time, 10);
      check("bp_overrun_set", overrun, 1);
      ready = 1'b1;
      seg(1'b0, 1);
      exp_q.delete();
      check("bp_valid_cleared", valid, 0);
      check("bp_overrun_sticky", overrun, 1);
      clr_err = 1'b1;
      seg(1'b0, 1);
      clr_err = 1'b0;
      check("bp_overrun_cleared", overrun, 0);
      for (int i = 0; i < 4; i++) begin
         seg(1'b1, 10);
         seg(1'b0, 10);
      end
      seg(1'b1, 10);
      seg(1'b0, 10);
      check("bp_queue_empty", exp_q.size(), 0);
      check("bp_overrun_stays_clear", overrun, 0);

      // stuck input: stop after a rise, then resume at period 50
      for (int i = 0; i < 3; i++) begin
         seg(1'b1, 25);
         seg(1'b0, 25);
      end
      model_seg(1'b1, 25);
      in_clk = 1'b1;
      k = 0;
      while (valid !== 1'b1 && k < 20) begin
         tick(1);
         k++;
      end
      check("stuck_last_result_valid", valid, 1);
      for (int i = 1; i <= TO; i++) begin
         tick(1);
         if (k + i == 25) in_clk = 1'b0;
         if (i == TO - 1) check("stuck_not_yet", stuck, 0);
         if (i == TO) check("stuck_at_timeout", stuck, 1);
      end
      tick(20);
      model_seg(1'b0, k + TO + 20 - 25);
      check("stuck_holds", stuck, 1);
      seg(1'b1, 25);
      check("stuck_cleared_by_rise", stuck, 0);
      seg(1'b0, 25);
      for (int i = 0; i < 3; i++) begin
         seg(1'b1, 25);
         seg(1'b0, 25);
      end
      seg(1'b1, 25);
      seg(1'b0, 25);
      check("resume_queue_empty", exp_q.size(), 0);
      check("resume_period", period, 50);
      check("resume_stuck", stuck, 0);

      // reset in the middle of a 1000-cycle period
      for (int i = 0; i < 3; i++) begin
         seg(1'b1, 300);
         seg(1'b0, 700);
      end
      seg(1'b1, 300);
      seg(1'b0, 100);
      check("prereset_queue_empty", exp_q.size(), 0);
      check("prereset_period", period, 1000);
      rst_n = 1'b0;
      #1;
      check("midreset_period", period, 0);
      check("midreset_high", high_time, 0);
      check("midreset_valid", valid, 0);
      check("midreset_overrun", overrun, 0);
      check("midreset_stuck", stuck, 0);
      model_reset();
      tick(3);
      rst_n = 1'b1;
      base = n_acc;
      seg(1'b1, 300);
      seg(1'b0, 700);
      check("postreset_no_result_after_one_rise", n_acc - base, 0);
      seg(1'b1, 300);
      seg(1'b0, 700);
      seg(1'b1, 300);
      seg(1'b0, 50);
      check("postreset_result_count", n_acc - base, 2);
      check("postreset_queue_empty", exp_q.size(), 0);
      check("postreset_period", period, 1000);
      check("postreset_high", high_time, 300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
